// File: rtl/pwm_sample_scheduler.sv
// rtl/pwm_sample_scheduler.sv - sample FIFO and config shadow feeding the PWM stage
module pwm_sample_scheduler #(
  parameter int BITS       = 11,
  parameter int DEPTH_LOG2 = 2,
  parameter int REP_BITS   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BITS-1:0]       in_sample,
  input  logic                  cfg_write,
  input  logic [BITS-1:0]       cfg_compare_max,
  input  logic                  cfg_dual_slope_en,
  input  logic                  cfg_double_slope_en,
  input  logic                  cfg_ddr_en,
  input  logic [REP_BITS-1:0]   cfg_repeat,
  output logic                  cfg_pending,
  input  logic                  pulse_done,
  output logic [BITS-1:0]       pulse_width,
  output logic [BITS-1:0]       compare_max,
  output logic                  dual_slope_en,
  output logic                  double_slope_en,
  output logic                  ddr_en,
  output logic                  pwm_reset,
  output logic [DEPTH_LOG2:0]   fifo_level,
  output logic [7:0]            underflow_count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [BITS-1:0] CMAX_RST = BITS'((1 << (BITS - 1)) - 1);
  localparam logic [DEPTH_LOG2:0] LEVEL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    RECONFIG = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [BITS-1:0]       mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;

  logic [BITS-1:0]     pw_q, pw_d;
  logic [REP_BITS-1:0] rep_cnt_q, rep_cnt_d;
  logic [7:0]          uf_q, uf_d;

  logic [BITS-1:0]     cmax_q, cmax_d;
  logic                dual_q, dual_d;
  logic                dbl_q, dbl_d;
  logic                ddr_q, ddr_d;
  logic [REP_BITS-1:0] rep_q, rep_d;

  logic [BITS-1:0]     sh_cmax_q, sh_cmax_d;
  logic                sh_dual_q, sh_dual_d;
  logic                sh_dbl_q, sh_dbl_d;
  logic                sh_ddr_q, sh_ddr_d;
  logic [REP_BITS-1:0] sh_rep_q, sh_rep_d;
  logic                pending_q, pending_d;

  logic push, pop, fifo_empty;

  assign fifo_empty = (level_q == '0);
  assign in_ready   = (level_q != LEVEL_FULL) && !reset;
  assign push       = in_valid && in_ready;

  always_comb begin
    state_d   = state_q;
    pw_d      = pw_q;
    rep_cnt_d = rep_cnt_q;
    uf_d      = uf_q;
    cmax_d    = cmax_q;
    dual_d    = dual_q;
    dbl_d     = dbl_q;
    ddr_d     = ddr_q;
    rep_d     = rep_q;
    sh_cmax_d = sh_cmax_q;
    sh_dual_d = sh_dual_q;
    sh_dbl_d  = sh_dbl_q;
    sh_ddr_d  = sh_ddr_q;
    sh_rep_d  = sh_rep_q;
    pending_d = pending_q;
    pop       = 1'b0;

    case (state_q)
      IDLE: begin
        pw_d = '0;
        // PWM is held in reset here, so config can go live without a restart
        if (cfg_write) begin
          cmax_d = cfg_compare_max;  dual_d = cfg_dual_slope_en;
          dbl_d  = cfg_double_slope_en; ddr_d = cfg_ddr_en; rep_d = cfg_repeat;
          sh_cmax_d = cfg_compare_max;  sh_dual_d = cfg_dual_slope_en;
          sh_dbl_d  = cfg_double_slope_en; sh_ddr_d = cfg_ddr_en; sh_rep_d = cfg_repeat;
          pending_d = 1'b0;
        end else if (pending_q) begin
          cmax_d = sh_cmax_q; dual_d = sh_dual_q; dbl_d = sh_dbl_q;
          ddr_d  = sh_ddr_q;  rep_d  = sh_rep_q;
          pending_d = 1'b0;
        end
        if (enable && !fifo_empty) begin
          pop       = 1'b1;
          pw_d      = mem_q[rd_ptr_q];
          rep_cnt_d = rep_q;
          state_d   = RUN;
        end
      end

      RUN: begin
        if (pulse_done) begin
          if (rep_cnt_q != '0) begin
            rep_cnt_d = rep_cnt_q - 1'b1;
          end else if (!enable) begin
            pw_d    = '0;
            state_d = IDLE;
          end else begin
            rep_cnt_d = rep_q;
            if (pending_q) begin
              cmax_d = sh_cmax_q; dual_d = sh_dual_q; dbl_d = sh_dbl_q;
              ddr_d  = sh_ddr_q;  rep_d  = sh_rep_q;
              rep_cnt_d = sh_rep_q;
              pending_d = 1'b0;
              state_d   = RECONFIG;
            end
            if (!fifo_empty) begin
              pop  = 1'b1;
              pw_d = mem_q[rd_ptr_q];
            end else if (uf_q != 8'hFF) begin
              uf_d = uf_q + 8'd1;
            end
          end
        end
      end

      RECONFIG: state_d = RUN;

      default: state_d = IDLE;
    endcase

    // A write coinciding with an apply stays pending; the apply used the old shadow
    if (cfg_write && state_q != IDLE) begin
      sh_cmax_d = cfg_compare_max;  sh_dual_d = cfg_dual_slope_en;
      sh_dbl_d  = cfg_double_slope_en; sh_ddr_d = cfg_ddr_en; sh_rep_d = cfg_repeat;
      pending_d = 1'b1;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      level_d = level_q + 1'b1;
    else if (pop && !push) level_d = level_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_sample;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      pw_q      <= '0;
      rep_cnt_q <= '0;
      uf_q      <= '0;
      cmax_q    <= CMAX_RST;
      dual_q    <= 1'b0;
      dbl_q     <= 1'b0;
      ddr_q     <= 1'b0;
      rep_q     <= '0;
      sh_cmax_q <= CMAX_RST;
      sh_dual_q <= 1'b0;
      sh_dbl_q  <= 1'b0;
      sh_ddr_q  <= 1'b0;
      sh_rep_q  <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      pw_q      <= pw_d;
      rep_cnt_q <= rep_cnt_d;
      uf_q      <= uf_d;
      cmax_q    <= cmax_d;
      dual_q    <= dual_d;
      dbl_q     <= dbl_d;
      ddr_q     <= ddr_d;
      rep_q     <= rep_d;
      sh_cmax_q <= sh_cmax_d;
      sh_dual_q <= sh_dual_d;
      sh_dbl_q  <= sh_dbl_d;
      sh_ddr_q  <= sh_ddr_d;
      sh_rep_q  <= sh_rep_d;
      pending_q <= pending_d;
    end
  end

  assign pulse_width     = pw_q;
  assign compare_max     = cmax_q;
  assign dual_slope_en   = dual_q;
  assign double_slope_en = dbl_q;
  assign ddr_en          = ddr_q;
  assign cfg_pending     = pending_q;
  assign pwm_reset       = (state_q != RUN);
  assign fifo_level      = level_q;
  assign underflow_count = uf_q;

endmodule

// File: tb/tb_pwm_sample_scheduler.sv
// tb/tb_pwm_sample_scheduler.sv - scoreboard bench for pwm_sample_scheduler
module tb_pwm_sample_scheduler;

  logic        clk = 1'b0;
  logic        reset, enable, in_valid, in_ready;
  logic [10:0] in_sample;
  logic        cfg_write, cfg_dual_slope_en, cfg_double_slope_en, cfg_ddr_en;
  logic [10:0] cfg_compare_max;
  logic [3:0]  cfg_repeat;
  logic        cfg_pending, pulse_done;
  logic [10:0] pulse_width, compare_max;
  logic        dual_slope_en, double_slope_en, ddr_en, pwm_reset;
  logic [2:0]  fifo_level;
  logic [7:0]  underflow_count;

  int checks = 0;
  int errors = 0;
  logic [10:0] exp_q[$];
  logic [10:0] last_pw = '0;

  pwm_sample_scheduler dut (
    .clk(clk), .reset(reset), .enable(enable),
    .in_valid(in_valid), .in_ready(in_ready), .in_sample(in_sample),
    .cfg_write(cfg_write), .cfg_compare_max(cfg_compare_max),
    .cfg_dual_slope_en(cfg_dual_slope_en), .cfg_double_slope_en(cfg_double_slope_en),
    .cfg_ddr_en(cfg_ddr_en), .cfg_repeat(cfg_repeat), .cfg_pending(cfg_pending),
    .pulse_done(pulse_done), .pulse_width(pulse_width), .compare_max(compare_max),
    .dual_slope_en(dual_slope_en), .double_slope_en(double_slope_en), .ddr_en(ddr_en),
    .pwm_reset(pwm_reset), .fifo_level(fifo_level), .underflow_count(underflow_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Every new nonzero pulse_width must be the next sample the bench pushed
  always @(negedge clk) begin
    if (!reset && pulse_width != last_pw && pulse_width != '0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sample_stream: got %h, expected none outstanding", pulse_width);
      end else begin
        logic [10:0] e;
        e = exp_q.pop_front();
        if (pulse_width != e) begin
          errors++;
          $display("FAIL sample_stream: got %h, expected %h", pulse_width, e);
        end
      end
    end
    last_pw = pulse_width;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [10:0] v);
    in_valid  = 1'b1;
    in_sample = v;
    tick();
    in_valid  = 1'b0;
    exp_q.push_back(v);
  endtask

  task automatic pulse();
    pulse_done = 1'b1;
    tick();
    pulse_done = 1'b0;
  endtask

  task automatic cfg(input logic [10:0] cm, input logic dbl, input logic [3:0] rep);
    cfg_compare_max     = cm;
    cfg_double_slope_en = dbl;
    cfg_dual_slope_en   = 1'b0;
    cfg_ddr_en          = 1'b0;
    cfg_repeat          = rep;
    cfg_write           = 1'b1;
    tick();
    cfg_write           = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'h0);
    chk({tag, "_level"}, 32'(fifo_level), 32'h0);
    chk({tag, "_pw"}, 32'(pulse_width), 32'h0);
    chk({tag, "_cmax"}, 32'(compare_max), 32'h3FF);
    chk({tag, "_modes"}, {29'b0, dual_slope_en, double_slope_en, ddr_en}, 32'h0);
    chk({tag, "_pending"}, 32'(cfg_pending), 32'h0);
    chk({tag, "_uf"}, 32'(underflow_count), 32'h0);
    chk({tag, "_pwm_reset"}, 32'(pwm_reset), 32'h1);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; in_valid = 1'b0; in_sample = '0;
    cfg_write = 1'b0; cfg_compare_max = '0; cfg_dual_slope_en = 1'b0;
    cfg_double_slope_en = 1'b0; cfg_ddr_en = 1'b0; cfg_repeat = '0; pulse_done = 1'b0;
    tick(); tick();
    chk_reset_state("rst");
    reset = 1'b0;
    tick();
    chk("ready_after_rst", 32'(in_ready), 32'h1);

    // Basic flow
    push(11'h100);
    push(11'h200);
    chk("level2", 32'(fifo_level), 32'h2);
    enable = 1'b1;
    tick();
    chk("start_pw", 32'(pulse_width), 32'h100);
    chk("start_pwm_reset", 32'(pwm_reset), 32'h0);
    pulse();
    chk("second_pw", 32'(pulse_width), 32'h200);
    chk("level0", 32'(fifo_level), 32'h0);
    pulse();
    chk("uf_first", 32'(underflow_count), 32'h1);
    chk("uf_hold", 32'(pulse_width), 32'h200);

    // enable drop waits for the boundary
    enable = 1'b0;
    tick();
    chk("dis_still_run", 32'(pwm_reset), 32'h0);
    pulse();
    chk("dis_idle_rst", 32'(pwm_reset), 32'h1);
    chk("dis_idle_pw", 32'(pulse_width), 32'h0);

    // Repeat count of 2 set directly in IDLE
    cfg(11'h3FF, 1'b0, 4'd2);
    chk("idle_cfg_pending", 32'(cfg_pending), 32'h0);
    push(11'h010);
    push(11'h020);
    enable = 1'b1;
    tick();
    pulse();
    pulse();
    chk("rep_hold", 32'(pulse_width), 32'h010);
    pulse();
    chk("rep_next", 32'(pulse_width), 32'h020);
    enable = 1'b0;
    for (int i = 0; i < 3; i++) pulse();
    chk("rep_idle", 32'(pwm_reset), 32'h1);

    // Underflow saturation
    cfg(11'h3FF, 1'b0, 4'd0);
    push(11'h055);
    enable = 1'b1;
    tick();
    pulse();
    chk("uf_hold55", 32'(pulse_width), 32'h055);
    chk("uf_count2", 32'(underflow_count), 32'h2);
    for (int i = 0; i < 299; i++) pulse();
    chk("uf_sat", 32'(underflow_count), 32'hFF);

    // Shadowed reconfiguration at a boundary
    cfg(11'h0FF, 1'b1, 4'd0);
    chk("cfg_pending_set", 32'(cfg_pending), 32'h1);
    chk("cmax_not_yet", 32'(compare_max), 32'h3FF);
    push(11'h066);
    pulse();
    chk("rc_cmax", 32'(compare_max), 32'h0FF);
    chk("rc_dbl", 32'(double_slope_en), 32'h1);
    chk("rc_pwm_reset", 32'(pwm_reset), 32'h1);
    chk("rc_pending", 32'(cfg_pending), 32'h0);
    tick();
    chk("rc_one_cycle", 32'(pwm_reset), 32'h0);

    // Write in the same cycle as an apply stays pending
    cfg(11'h1AA, 1'b1, 4'd0);
    push(11'h077);
    cfg_compare_max = 11'h0CC;
    cfg_write  = 1'b1;
    pulse_done = 1'b1;
    tick();
    cfg_write  = 1'b0;
    pulse_done = 1'b0;
    chk("race_cmax", 32'(compare_max), 32'h1AA);
    chk("race_pending", 32'(cfg_pending), 32'h1);
    tick();

    // FIFO full and simultaneous push/pop
    for (int i = 1; i <= 4; i++) push(11'h100 + 11'(i));
    chk("full_ready", 32'(in_ready), 32'h0);
    in_valid = 1'b1; in_sample = 11'h105;
    tick();
    in_valid = 1'b0;
    chk("full_level", 32'(fifo_level), 32'h4);
    pulse();
    chk("full_pop_cmax", 32'(compare_max), 32'h0CC);
    chk("full_pop_level", 32'(fifo_level), 32'h3);
    tick();
    in_valid = 1'b1; in_sample = 11'h106; pulse_done = 1'b1;
    tick();
    in_valid = 1'b0; pulse_done = 1'b0;
    exp_q.push_back(11'h106);
    chk("pushpop_level", 32'(fifo_level), 32'h3);
    chk("pushpop_pw", 32'(pulse_width), 32'h102);

    // Reset mid-run discards everything
    exp_q.delete();
    reset = 1'b1;
    tick();
    chk_reset_state("midrst");
    reset = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_sample_scheduler.md
Name: pwm_sample_scheduler

Overview:
- Feeds the PWM stage of the noise-shaping DAC.
- Buffers incoming pulse-width samples in a small FIFO and presents one sample per PWM period, repeated a configurable number of periods.
- Shadows the PWM configuration (period, slope modes, DDR) and applies changes only at a sample boundary, restarting the PWM counter cleanly.
- Counts underflows for the host.

Parameters:
BITS, 11, width of pulse_width and compare_max
DEPTH_LOG2, 2, log2 of FIFO depth (4 entries)
REP_BITS, 4, width of per-sample repeat count

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
enable  in  1  run request; sampled at boundaries
in_valid  in  1  sample valid
in_ready  out  1  FIFO can accept; equals !full && !reset
in_sample  in  BITS  pulse width sample
cfg_write  in  1  one-cycle strobe, captures cfg_* into shadow
cfg_compare_max  in  BITS  new PWM period
cfg_dual_slope_en, cfg_double_slope_en, cfg_ddr_en  in  1 each  new mode bits
cfg_repeat  in  REP_BITS  periods per sample minus one
cfg_pending  out  1  shadow holds an unapplied config
pulse_done  in  1  from PWM; next value needed next cycle
pulse_width  out  BITS  registered sample to PWM
compare_max  out  BITS  active period
dual_slope_en, double_slope_en, ddr_en  out  1 each  active modes
pwm_reset  out  1  holds/restarts PWM counter
fifo_level  out  DEPTH_LOG2+1  entries stored
underflow_count  out  8  saturating underflow counter

Behaviour:
- Reset values:
  - FIFO empty, fifo_level=0, in_ready=0.
  - pulse_width=0, compare_max=2^(BITS-1)-1, all mode outputs 0, active repeat=0.
  - Shadow equals active config, cfg_pending=0, underflow_count=0.
  - State IDLE, pwm_reset=1.
- FIFO:
  - Push when in_valid && in_ready.
  - Push and pop in the same cycle leave the level unchanged.
  - Pop on an empty FIFO never occurs. When full, in_ready=0 and there is no bypass.
- Boundary: the cycle where state=RUN, pulse_done=1 and rep_cnt==0.
- States:
  - IDLE:
    - pwm_reset=1, pulse_width=0.
    - cfg_write copies straight to the active config next cycle; cfg_pending stays 0.
    - If enable=1 and fifo_level>=1: pop head into pulse_width, rep_cnt<=active repeat, go RUN. pwm_reset is 0 from the next cycle.
  - RUN:
    - pulse_done with rep_cnt!=0: rep_cnt--, pulse_width held.
    - At a boundary, evaluate in this priority order:
      1. enable=0: go IDLE; pulse_width<=0.
      2. cfg_pending=1: apply shadow to active outputs, clear cfg_pending, load next sample (same rules as 3), go RECONFIG.
      3. Otherwise, FIFO non-empty: pop into pulse_width, rep_cnt<=active repeat.
      4. FIFO empty: hold pulse_width, rep_cnt<=active repeat, underflow_count++ (saturating at 255).
    - cfg_write outside IDLE: shadow<=cfg_*, cfg_pending<=1. Last write wins.
  - RECONFIG:
    - Lasts one cycle. pwm_reset=1 with the new config already on the outputs, so the PWM restarts its counter under the new slope mode.
    - pulse_done is ignored. Then go RUN.
- Latency: pulse_width changes the cycle after the pulse_done that triggered the pop, meeting the PWM "next cycle" contract.
- cfg_write in the same cycle as a boundary apply: the apply uses the pre-write shadow; the new write remains pending.
- pulse_done is ignored in IDLE and RECONFIG.
- Reset mid-operation restores all reset values immediately; FIFO contents are discarded.

Test Plan:
- Reset, push 0x100, 0x200; enable=1 -> RUN; pulse_width=0x100 the cycle after the pop, pwm_reset falls. First pulse_done -> pulse_width=0x200 next cycle, fifo_level=0.
- cfg_repeat=2 written in IDLE, push 0x010 and 0x020 -> 0x010 held across 3 pulse_done pulses; 0x020 appears after the third.
- FIFO empty at a boundary with pulse_width=0x055 -> pulse_width stays 0x055, underflow_count increments by 1 per boundary. After 300 boundaries it reads 255.
- In RUN, cfg_write with compare_max=0x0FF and double_slope_en=1 mid-sample:
  - cfg_pending=1 until the boundary.
  - At the boundary, compare_max=0x0FF and double_slope_en=1, pwm_reset high exactly one cycle, cfg_pending=0.
- Push 5 samples back-to-back with DEPTH_LOG2=2 -> in_ready low after the 4th, 5th held off. Push and pop in the same cycle while full-minus-one -> fifo_level unchanged.
- enable=0 in RUN -> state stays RUN until the boundary, then IDLE with pwm_reset=1 and pulse_width=0. Assert reset mid-RUN -> all outputs at reset values the next cycle.
